// File: rtl/instr_dispatcher_pkg.sv
// PIM instruction-set definitions shared by the dispatcher and Controller decode.
package pim_isa_pkg;

    // Opcodes
    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_MUL   = 6'd2;
    localparam logic [5:0] OP_EAST  = 6'd5;
    localparam logic [5:0] OP_SOUTH = 6'd7;
    localparam logic [5:0] OP_NORTH = 6'd8;
    localparam logic [5:0] OP_MSB0  = 6'd9;
    localparam logic [5:0] OP_MSB1  = 6'd10;
    localparam logic [5:0] OP_HALT  = 6'd63;

    // Instruction word field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS1_HI = 20;
    localparam int RS1_LO = 16;
    localparam int RS2_HI = 15;
    localparam int RS2_LO = 11;

    // Dispatcher sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } disp_state_t;

    // Opcodes the datapath can execute (west shifts are not wired up).
    function automatic logic op_legal(input logic [5:0] opcode);
        logic legal;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_EAST, OP_SOUTH,
            OP_NORTH, OP_MSB0, OP_MSB1: legal = 1'b1;
            default:                    legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Number of cycles the Controller needs to finish an op on LENGTH-bit slices.
    function automatic int unsigned op_budget(input logic [5:0] opcode, input int unsigned length);
        int unsigned budget;
        case (opcode)
            OP_ADD, OP_SUB, OP_MSB0, OP_MSB1: budget = 32'd2 * length + 32'd2;
            OP_MUL:   budget = (length + 32'd1) * (32'd2 * length + 32'd5) + 32'd2;
            OP_EAST, OP_NORTH: budget = length + 32'd3;
            OP_SOUTH: budget = length + 32'd2;
            default:  budget = 32'd0;
        endcase
        return budget;
    endfunction

endpackage

// File: rtl/instr_dispatcher_mem.sv
// Program store: one synchronous write port, one synchronous read port.
// A read and write to the same slot in one cycle returns the old word.
module instr_mem_1r1w
    import pim_isa_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, sampled before the same-edge write lands.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_dispatcher.sv
// Issue side of the Controller command interface: fetches program words in
// order, pulses start per op and waits a fixed per-opcode cycle budget.
module instr_dispatcher
    import pim_isa_pkg::*;
#(
    parameter int unsigned LENGTH     = 32,
    parameter int          IMEM_DEPTH = 64,
    parameter int          PC_W       = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [31:0]     prog_data,
    output logic [31:0]     instruction,
    output logic            start,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     retired
);

    localparam int unsigned MUL_BUDGET = op_budget(OP_MUL, LENGTH);

    // The wait counter is 16 bits; the longest op must fit.
    if (MUL_BUDGET >= 32'd65536) begin : g_cfg_check
        $error("instr_dispatcher: LENGTH too large, mul budget exceeds 16-bit wait counter");
    end

    disp_state_t     state_r, state_s;
    logic [PC_W-1:0] pc_r, pc_s;
    logic [15:0]     retired_r, retired_s;
    logic            error_r, error_s;
    logic [31:0]     instr_r, instr_s;
    logic [15:0]     wait_cnt_r, wait_cnt_s;
    logic            start_r, start_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;

    logic [31:0]     rdata_s;
    logic [5:0]      opcode_s;
    logic            mem_we_s;
    logic            mem_re_s;
    logic            cur_busy_s;

    assign opcode_s = rdata_s[OPC_HI:OPC_LO];

    // Host writes are only accepted while no program is executing.
    always_comb begin
        cur_busy_s = (state_r == ST_FETCH) || (state_r == ST_DECODE) ||
                     (state_r == ST_ISSUE) || (state_r == ST_WAIT);
        mem_we_s   = prog_we && !cur_busy_s;
        mem_re_s   = (state_s == ST_FETCH);
    end

    instr_mem_1r1w #(
        .DEPTH  (IMEM_DEPTH),
        .ADDR_W (PC_W),
        .DATA_W (32)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (mem_re_s),
        .raddr (pc_s),
        .rdata (rdata_s)
    );

    // Next-state and next-output logic of the dispatch sequencer.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        retired_s  = retired_r;
        error_s    = error_r;
        instr_s    = instr_r;
        wait_cnt_s = wait_cnt_r;

        case (state_r)
            ST_IDLE, ST_ERROR: begin
                if (run) begin
                    state_s   = ST_FETCH;
                    pc_s      = {PC_W{1'b0}};
                    retired_s = 16'd0;
                    error_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                state_s = ST_DECODE;
            end
            ST_DECODE: begin
                if (opcode_s == OP_HALT) begin
                    state_s = ST_DONE;
                end else if (op_legal(opcode_s)) begin
                    state_s = ST_ISSUE;
                    instr_s = rdata_s;
                end else begin
                    // Faulting word stays visible for diagnosis.
                    state_s = ST_ERROR;
                    instr_s = rdata_s;
                    error_s = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_s    = ST_WAIT;
                wait_cnt_s = 16'(op_budget(instr_r[OPC_HI:OPC_LO], LENGTH));
            end
            ST_WAIT: begin
                if (wait_cnt_r <= 16'd1) begin
                    retired_s = (retired_r == 16'hFFFF) ? retired_r : retired_r + 16'd1;
                    if (pc_r == PC_W'(IMEM_DEPTH - 1)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                        pc_s    = pc_r + PC_W'(32'd1);
                    end
                end else begin
                    wait_cnt_s = wait_cnt_r - 16'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        start_s = (state_s == ST_ISSUE);
        done_s  = (state_s == ST_DONE);
        busy_s  = (state_s == ST_FETCH) || (state_s == ST_DECODE) ||
                  (state_s == ST_ISSUE) || (state_s == ST_WAIT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            pc_r       <= {PC_W{1'b0}};
            retired_r  <= 16'd0;
            error_r    <= 1'b0;
            instr_r    <= 32'd0;
            wait_cnt_r <= 16'd0;
            start_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            retired_r  <= retired_s;
            error_r    <= error_s;
            instr_r    <= instr_s;
            wait_cnt_r <= wait_cnt_s;
            start_r    <= start_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign instruction = instr_r;
    assign start       = start_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign pc          = pc_r;
    assign retired     = retired_r;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed scoreboard bench for instr_dispatcher (LENGTH=32).
module tb_instr_dispatcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] instruction;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  pc;
    logic [15:0] retired;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] instr;
    } exp_start_t;

    exp_start_t start_q[$];
    int         done_q[$];

    instr_dispatcher #(.LENGTH(32), .IMEM_DEPTH(64), .PC_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .pc          (pc),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2);
        return {6'(op), 5'(rd), 5'(rs1), 5'(rs2), 11'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every start/done pulse must match the next expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && start === 1'b1) begin
            check("start_expected", 32'(start_q.size() != 0), 32'd1);
            if (start_q.size() != 0) begin
                exp_start_t e;
                e = start_q.pop_front();
                check("start_cycle", 32'(cyc), 32'(e.cyc));
                check("start_instr", instruction, e.instr);
            end
        end
        if (reset === 1'b1 && done === 1'b1) begin
            check("done_expected", 32'(done_q.size() != 0), 32'd1);
            check("busy_at_done", 32'(busy), 32'd0);
            if (done_q.size() != 0) begin
                int d;
                d = done_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(d));
            end
        end
    end

    task automatic load(input int addr, input logic [31:0] data);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 6'(addr);
        prog_data = data;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic do_run(output int c0);
        @(negedge clk);
        run = 1'b1;
        c0  = cyc;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic do_run_we(input int addr, input logic [31:0] data, output int c0);
        @(negedge clk);
        run       = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 6'(addr);
        prog_data = data;
        c0        = cyc;
        @(negedge clk);
        run       = 1'b0;
        prog_we   = 1'b0;
    endtask

    // Wait for all expected pulses, bounded; then settle to the next negedge.
    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((start_q.size() != 0 || done_q.size() != 0) && n < bound) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(start_q.size() + done_q.size()), 32'd0);
        start_q.delete();
        done_q.delete();
        @(negedge clk);
    endtask

    task automatic wait_error(input int bound);
        int n;
        n = 0;
        while (error !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int c0;
        logic [31:0] w_add, w_halt;

        w_add  = enc(0, 3, 1, 2);
        w_halt = enc(63, 0, 0, 0);
        reset = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = 6'd0; prog_data = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_instruction", instruction, 32'd0);
        check("rst_flags", {28'd0, start, busy, done, error}, 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        reset = 1'b1;

        // add; HALT
        load(0, w_add);
        load(1, w_halt);
        do_run(c0);
        start_q.push_back('{c0 + 3, 32'h0061_1000});
        done_q.push_back(c0 + 72);
        drain(200);
        check("add_retired", 32'(retired), 32'd1);
        check("add_pc", 32'(pc), 32'd1);
        check("add_instr_hold", instruction, 32'h0061_1000);
        check("add_busy", 32'(busy), 32'd0);

        // east; south; north; HALT
        load(0, enc(5, 1, 2, 3));
        load(1, enc(7, 4, 5, 6));
        load(2, enc(8, 7, 8, 9));
        load(3, w_halt);
        do_run(c0);
        start_q.push_back('{c0 + 3,  enc(5, 1, 2, 3)});
        start_q.push_back('{c0 + 41, enc(7, 4, 5, 6)});
        start_q.push_back('{c0 + 78, enc(8, 7, 8, 9)});
        done_q.push_back(c0 + 116);
        drain(300);
        check("nsew_retired", 32'(retired), 32'd3);

        // mul; HALT
        load(0, enc(2, 10, 11, 12));
        load(1, w_halt);
        do_run(c0);
        start_q.push_back('{c0 + 3, enc(2, 10, 11, 12)});
        done_q.push_back(c0 + 2285);
        drain(2600);
        check("mul_retired", 32'(retired), 32'd1);

        // add; illegal 6; add
        load(0, w_add);
        load(1, enc(6, 1, 1, 1));
        load(2, w_add);
        do_run(c0);
        start_q.push_back('{c0 + 3, w_add});
        wait_error(200);
        check("err_cycle", 32'(cyc - c0), 32'd72);
        check("err_pc", 32'(pc), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_retired", 32'(retired), 32'd1);
        repeat (80) @(negedge clk);
        check("err_sticky", 32'(error), 32'd1);
        check("err_no_pending", 32'(start_q.size()), 32'd0);
        do_run(c0);
        check("rerun_err_clr", 32'(error), 32'd0);
        check("rerun_pc", 32'(pc), 32'd0);
        check("rerun_busy", 32'(busy), 32'd1);
        start_q.push_back('{c0 + 3, w_add});
        wait_error(200);
        check("err2_cycle", 32'(cyc - c0), 32'd72);

        // Reset during mul WAIT, then re-run
        load(0, enc(2, 10, 11, 12));
        load(1, w_halt);
        do_run(c0);
        start_q.push_back('{c0 + 3, enc(2, 10, 11, 12)});
        repeat (99) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_instruction", instruction, 32'd0);
        check("abort_flags", {28'd0, start, busy, done, error}, 32'd0);
        check("abort_pc", 32'(pc), 32'd0);
        check("abort_retired", 32'(retired), 32'd0);
        reset = 1'b1;
        do_run(c0);
        start_q.push_back('{c0 + 3, enc(2, 10, 11, 12)});
        done_q.push_back(c0 + 2285);
        drain(2600);
        check("abort_rerun_retired", 32'(retired), 32'd1);

        // 64 adds, no HALT; write while busy must be ignored
        for (int i = 0; i < 64; i++) load(i, enc(0, i % 32, 1, 2));
        do_run(c0);
        for (int k = 0; k < 64; k++) start_q.push_back('{c0 + 3 + 69 * k, enc(0, k % 32, 1, 2)});
        done_q.push_back(c0 + 3 + 69 * 63 + 67);
        load(5, w_halt);
        drain(5000);
        check("full_pc", 32'(pc), 32'd63);
        check("full_retired", 32'(retired), 32'd64);

        // run + write to slot 0 in the same cycle: fetch sees old word
        load(1, w_halt);
        do_run_we(0, w_halt, c0);
        start_q.push_back('{c0 + 3, enc(0, 0, 1, 2)});
        done_q.push_back(c0 + 72);
        drain(200);
        do_run_we(0, enc(5, 1, 1, 1), c0);
        done_q.push_back(c0 + 3);
        drain(50);
        check("halt_retired", 32'(retired), 32'd0);
        check("halt_instr_hold", instruction, enc(0, 0, 1, 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
